// File: rtl/pulse_trig_sched.sv
// pulse_trig_sched
//   Arm/trigger sequencer for the pulse_logic engine. Picks a soft or external
//   trigger, fires a one-cycle restart pulse into pulse_logic, counts completed
//   sequences (seq_done = pulse_logic trig_out) and inserts a holdoff between shots.
//
//   Optional build macro: TRIG_TIMESTAMP_EN adds a free-running cycle counter
//   and the trig_ts output, which latches that counter on every ARMED->FIRE.
//
// Ports
//   clk          pulse clock, posedge
//   rst          synchronous active-high reset
//   arm          strobe: IDLE -> ARMED, clears shots_done / missed_trig
//   disarm       strobe: abort to IDLE from any state (wins over arm)
//   soft_trig    software trigger, honoured in every trig_mode
//   trig_in      asynchronous external trigger
//   trig_mode    0 soft only, 1 ext rising, 2 ext falling, 3 ext either edge
//   shot_count   sequences per arm, 0 = infinite
//   holdoff      cycles spent in HOLDOFF after each shot, 0 = none
//   seq_done     end-of-sequence pulse from pulse_logic
//   pl_reset     restart pulse to pulse_logic (one cycle per accepted trigger)
//   armed        high in ARMED
//   running      high in FIRE or RUN
//   done         one-cycle pulse when the final shot completes
//   shots_done   completed sequences since last arm
//   missed_trig  triggers seen in FIRE/RUN/HOLDOFF since last arm, saturating
//   trig_ts      (TRIG_TIMESTAMP_EN only) cycle count at last accepted trigger
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | not armed, triggers ignored
// ARMED   | waiting for a trigger event
// FIRE    | pl_reset asserted for this single cycle
// RUN     | sequence in progress, waiting for seq_done
// HOLDOFF | dead time before re-arming
module pulse_trig_sched #(
  parameter int COUNT_BITS   = 32,
  parameter int HOLDOFF_BITS = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    arm,
  input  logic                    disarm,
  input  logic                    soft_trig,
  input  logic                    trig_in,
  input  logic [1:0]              trig_mode,
  input  logic [COUNT_BITS-1:0]   shot_count,
  input  logic [HOLDOFF_BITS-1:0] holdoff,
  input  logic                    seq_done,
  output logic                    pl_reset,
  output logic                    armed,
  output logic                    running,
  output logic                    done,
  output logic [COUNT_BITS-1:0]   shots_done,
  output logic [7:0]              missed_trig
`ifdef TRIG_TIMESTAMP_EN
  ,
  output logic [COUNT_BITS-1:0]   trig_ts
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_FIRE, S_RUN, S_HOLDOFF
  } state_t;

  state_t state, next_state;

  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    sync_last, hist_q;
  logic                    ext_edge, trg;
  logic [COUNT_BITS-1:0]   shots_inc;
  logic                    final_shot;
  logic [HOLDOFF_BITS-1:0] hold_cnt;
  logic                    arm_ok;

  // Synchroniser plus one history flop; history runs in every state so an
  // edge that straddles ARMED entry is still seen exactly once.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], trig_in};
      hist_q <= sync_last;
    end
  end

  assign sync_last = sync_q[SYNC_STAGES-1];

  always_comb begin
    ext_edge = 1'b0;
    case (trig_mode)
      2'd1:    ext_edge = sync_last & ~hist_q;
      2'd2:    ext_edge = ~sync_last & hist_q;
      2'd3:    ext_edge = sync_last ^ hist_q;
      default: ext_edge = 1'b0;
    endcase
  end

  assign trg        = soft_trig | ext_edge;
  assign shots_inc  = shots_done + {{(COUNT_BITS-1){1'b0}}, 1'b1};
  assign final_shot = (shot_count != '0) && (shots_inc == shot_count);
  assign arm_ok     = (state == S_IDLE) && arm && !disarm;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // FSM: next state
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    if (arm) next_state = S_ARMED;
      S_ARMED:   if (trg) next_state = S_FIRE;
      S_FIRE:    next_state = S_RUN;
      S_RUN: begin
        if (seq_done) begin
          if (final_shot)          next_state = S_IDLE;
          else if (holdoff == '0)  next_state = S_ARMED;
          else                     next_state = S_HOLDOFF;
        end
      end
      S_HOLDOFF: if (hold_cnt == {{(HOLDOFF_BITS-1){1'b0}}, 1'b1}) next_state = S_ARMED;
      default:   next_state = S_IDLE;
    endcase
    if (disarm) next_state = S_IDLE;
  end

  // FSM: outputs decoded from state
  always_comb begin
    pl_reset = 1'b0;
    armed    = 1'b0;
    running  = 1'b0;
    case (state)
      S_ARMED: armed = 1'b1;
      S_FIRE: begin
        pl_reset = 1'b1;
        running  = 1'b1;
      end
      S_RUN:   running = 1'b1;
      default: ;
    endcase
  end

  // Shot / missed-trigger bookkeeping, holdoff timer and done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      shots_done  <= '0;
      missed_trig <= '0;
      hold_cnt    <= '0;
      done        <= 1'b0;
    end else begin
      done <= (state == S_RUN) && seq_done && !disarm && final_shot;

      if (arm_ok)
        shots_done <= '0;
      else if ((state == S_RUN) && seq_done && !disarm)
        shots_done <= shots_inc;

      if (arm_ok)
        missed_trig <= '0;
      else if (trg && (state == S_FIRE || state == S_RUN || state == S_HOLDOFF)
               && (missed_trig != 8'hFF))
        missed_trig <= missed_trig + 8'd1;

      if ((state == S_RUN) && (next_state == S_HOLDOFF))
        hold_cnt <= holdoff;
      else if ((state == S_HOLDOFF) && (hold_cnt != '0))
        hold_cnt <= hold_cnt - {{(HOLDOFF_BITS-1){1'b0}}, 1'b1};
    end
  end

`ifdef TRIG_TIMESTAMP_EN
  logic [COUNT_BITS-1:0] ts_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_cnt  <= '0;
      trig_ts <= '0;
    end else begin
      ts_cnt <= ts_cnt + {{(COUNT_BITS-1){1'b0}}, 1'b1};
      if ((state == S_ARMED) && (next_state == S_FIRE))
        trig_ts <= ts_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_pulse_trig_sched.sv
module tb_pulse_trig_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arm = 1'b0;
  logic        disarm = 1'b0;
  logic        soft_trig = 1'b0;
  logic        trig_in = 1'b0;
  logic [1:0]  trig_mode = 2'd0;
  logic [31:0] shot_count = 32'd0;
  logic [15:0] holdoff = 16'd0;
  logic        seq_done = 1'b0;
  logic        pl_reset, armed, running, done;
  logic [31:0] shots_done;
  logic [7:0]  missed_trig;
`ifdef TRIG_TIMESTAMP_EN
  logic [31:0] trig_ts;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int exp_q[$];

  pulse_trig_sched #(.COUNT_BITS(32), .HOLDOFF_BITS(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .arm(arm), .disarm(disarm), .soft_trig(soft_trig),
    .trig_in(trig_in), .trig_mode(trig_mode), .shot_count(shot_count),
    .holdoff(holdoff), .seq_done(seq_done), .pl_reset(pl_reset), .armed(armed),
    .running(running), .done(done), .shots_done(shots_done), .missed_trig(missed_trig)
`ifdef TRIG_TIMESTAMP_EN
    , .trig_ts(trig_ts)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: each accepted trigger pushes the edge count after which
  // pl_reset must be high; every observed pulse pops one entry.
  always @(negedge clk) begin
    if (pl_reset) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pl_reset_unexpected: pulse at cyc=%0d, none expected", cyc);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (e != cyc) begin
          bad++;
          $display("FAIL pl_reset_timing: pulse at cyc=%0d, expected cyc=%0d", cyc, e);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_arm();
    arm = 1'b1; tick(); arm = 1'b0;
  endtask

  task automatic pulse_disarm();
    disarm = 1'b1; tick(); disarm = 1'b0;
  endtask

  task automatic pulse_seq_done();
    seq_done = 1'b1; tick(); seq_done = 1'b0;
  endtask

  task automatic soft_shot();
    soft_trig = 1'b1;
    exp_q.push_back(cyc + 1);
    tick();
    soft_trig = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(2); rst = 1'b0;
    total++; if (pl_reset !== 1'b0)  begin bad++; $display("FAIL reset_pl_reset: got %b want 0", pl_reset); end
    total++; if (armed !== 1'b0)     begin bad++; $display("FAIL reset_armed: got %b want 0", armed); end
    total++; if (running !== 1'b0)   begin bad++; $display("FAIL reset_running: got %b want 0", running); end
    total++; if (done !== 1'b0)      begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (shots_done !== 32'd0) begin bad++; $display("FAIL reset_shots: got %0d want 0", shots_done); end
    total++; if (missed_trig !== 8'd0) begin bad++; $display("FAIL reset_missed: got %0d want 0", missed_trig); end
  endtask

  task automatic test_soft_shots();
    trig_mode = 2'd0; shot_count = 32'd3; holdoff = 16'd0;
    pulse_arm();
    total++; if (armed !== 1'b1) begin bad++; $display("FAIL soft_armed: got %b want 1", armed); end
    for (int i = 0; i < 3; i++) begin
      soft_shot();
      tick(9);
      pulse_seq_done();
      total++; if (shots_done !== 32'(i + 1)) begin bad++; $display("FAIL soft_shots_%0d: got %0d want %0d", i, shots_done, i + 1); end
      total++; if (done !== (i == 2)) begin bad++; $display("FAIL soft_done_%0d: got %b want %b", i, done, i == 2); end
      total++; if (armed !== (i != 2)) begin bad++; $display("FAIL soft_rearm_%0d: got %b want %b", i, armed, i != 2); end
    end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL soft_done_width: got %b want 0", done); end
    total++; if (armed !== 1'b0 || running !== 1'b0) begin bad++; $display("FAIL soft_idle: armed=%b running=%b want 0 0", armed, running); end
  endtask

  task automatic test_ext_edges();
    trig_mode = 2'd1; shot_count = 32'd0; holdoff = 16'd0;
    pulse_arm();
    trig_in = 1'b1; exp_q.push_back(cyc + 3); tick(6);
    total++; if (running !== 1'b1) begin bad++; $display("FAIL ext_rise_run: got %b want 1", running); end
    pulse_seq_done();
    trig_in = 1'b0; tick(6);
    total++; if (armed !== 1'b1) begin bad++; $display("FAIL ext_fall_ignored: armed=%b want 1", armed); end
    trig_mode = 2'd2;
    trig_in = 1'b1; tick(6);
    total++; if (armed !== 1'b1) begin bad++; $display("FAIL ext_rise_ignored_m2: armed=%b want 1", armed); end
    trig_in = 1'b0; exp_q.push_back(cyc + 3); tick(6);
    total++; if (running !== 1'b1) begin bad++; $display("FAIL ext_fall_run: got %b want 1", running); end
    pulse_seq_done();
    trig_mode = 2'd3;
    trig_in = 1'b1; exp_q.push_back(cyc + 3); tick(6);
    pulse_seq_done();
    total++; if (shots_done !== 32'd3) begin bad++; $display("FAIL ext_shots: got %0d want 3", shots_done); end
    total++; if (missed_trig !== 8'd0) begin bad++; $display("FAIL ext_missed: got %0d want 0", missed_trig); end
    pulse_disarm();
    trig_in = 1'b0; tick(4);
    trig_mode = 2'd0;
  endtask

  task automatic test_holdoff();
    holdoff = 16'd5; shot_count = 32'd0;
    pulse_arm();
    soft_shot();
    tick(2);
    pulse_seq_done();
    for (int k = 0; k < 5; k++) begin
      total++; if (armed !== 1'b0) begin bad++; $display("FAIL holdoff_wait_%0d: armed=%b want 0", k, armed); end
      if (k == 1) soft_trig = 1'b1;
      tick();
      soft_trig = 1'b0;
    end
    total++; if (armed !== 1'b1) begin bad++; $display("FAIL holdoff_rearm: armed=%b want 1", armed); end
    total++; if (missed_trig !== 8'd1) begin bad++; $display("FAIL holdoff_missed: got %0d want 1", missed_trig); end
    soft_trig = 1'b1; exp_q.push_back(cyc + 1);
    tick(300);
    soft_trig = 1'b0;
    total++; if (missed_trig !== 8'hFF) begin bad++; $display("FAIL missed_saturate: got %0d want 255", missed_trig); end
    pulse_disarm();
  endtask

  task automatic test_disarm();
    holdoff = 16'd0; shot_count = 32'd2;
    total++; if (shots_done !== 32'd1) begin bad++; $display("FAIL disarm_hold: got %0d want 1", shots_done); end
    arm = 1'b1; disarm = 1'b1; tick(); arm = 1'b0; disarm = 1'b0;
    total++; if (armed !== 1'b0) begin bad++; $display("FAIL arm_disarm_same: armed=%b want 0", armed); end
    total++; if (shots_done !== 32'd1) begin bad++; $display("FAIL arm_disarm_noclear: got %0d want 1", shots_done); end
    pulse_arm();
    total++; if (shots_done !== 32'd0 || missed_trig !== 8'd0) begin bad++; $display("FAIL arm_clear: shots=%0d missed=%0d want 0 0", shots_done, missed_trig); end
    soft_shot(); tick(2); pulse_seq_done();
    soft_shot(); tick(2);
    pulse_disarm();
    total++; if (armed !== 1'b0 || running !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL disarm_run: armed=%b running=%b done=%b want 0 0 0", armed, running, done); end
    pulse_seq_done();
    total++; if (shots_done !== 32'd1 || done !== 1'b0) begin bad++; $display("FAIL disarm_seq_ignored: shots=%0d done=%b want 1 0", shots_done, done); end
  endtask

  task automatic test_reset_mid();
    shot_count = 32'd0; holdoff = 16'd0;
    pulse_arm();
    for (int i = 0; i < 7; i++) begin
      if (i == 6) holdoff = 16'd20;
      soft_shot(); tick(2); pulse_seq_done();
    end
    total++; if (shots_done !== 32'd7 || armed !== 1'b0 || running !== 1'b0) begin bad++; $display("FAIL mid_holdoff: shots=%0d armed=%b running=%b want 7 0 0", shots_done, armed, running); end
    rst = 1'b1; tick();
    total++; if (shots_done !== 32'd0 || missed_trig !== 8'd0 || armed !== 1'b0 || running !== 1'b0 || done !== 1'b0 || pl_reset !== 1'b0) begin
      bad++; $display("FAIL mid_reset: shots=%0d missed=%0d armed=%b running=%b done=%b pl=%b want all 0", shots_done, missed_trig, armed, running, done, pl_reset);
    end
    rst = 1'b0;
    trig_mode = 2'd1; holdoff = 16'd0;
    pulse_arm();
    trig_in = 1'b1; tick(2);
    soft_trig = 1'b1; exp_q.push_back(cyc + 1); tick(); soft_trig = 1'b0;
    tick(3);
    total++; if (missed_trig !== 8'd0 || running !== 1'b1) begin bad++; $display("FAIL combined_trig: missed=%0d running=%b want 0 1", missed_trig, running); end
    pulse_disarm();
    trig_in = 1'b0; trig_mode = 2'd0; tick(4);
  endtask

`ifdef TRIG_TIMESTAMP_EN
  task automatic test_timestamp();
    int r;
    rst = 1'b1; tick(); rst = 1'b0;
    r = cyc;
    total++; if (trig_ts !== 32'd0) begin bad++; $display("FAIL ts_reset: got %0d want 0", trig_ts); end
    pulse_arm();
    while (cyc < r + 100) tick();
    soft_shot();
    total++; if (trig_ts !== 32'd100) begin bad++; $display("FAIL ts_value: got %0d want 100", trig_ts); end
    pulse_disarm();
  endtask
`endif

  initial begin
    test_reset();
    test_soft_shots();
    test_ext_edges();
    test_holdoff();
    test_disarm();
    test_reset_mid();
`ifdef TRIG_TIMESTAMP_EN
    test_timestamp();
`endif
    tick(3);
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL pl_reset_missing: %0d pulses outstanding, want 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
